ssd_scan_mux: RTL and testbench
===============================

SSD_SCAN_MUX -- requirements
Module: ssd_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter PRESCALE, default 131072, clk cycles each digit stays lit (>=2).
REQ-003 SHALL have port clk  in  1  system clock; the block uses one clock, all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port load  in  1  single-cycle strobe that captures value, dec_mode and dp_in.
REQ-006 SHALL have port value  in  4*NUM_DIGITS  hex nibbles (dec_mode=0) or unsigned binary (dec_mode=1).
REQ-007 SHALL have port dec_mode  in  1  1 selects binary-to-decimal conversion.
REQ-008 SHALL have port dp_in  in  NUM_DIGITS  decimal point per digit, 1 means lit.
REQ-009 SHALL have port digit_en  in  NUM_DIGITS  live per-digit enable; 0 blanks that digit.
REQ-010 SHALL have port busy  out  1  conversion in progress.
REQ-011 SHALL have port ovf  out  1  last decimal load exceeded 10^NUM_DIGITS-1.
REQ-012 SHALL have port an  out  NUM_DIGITS  active-low anodes; bit i drives digit i, digit 0 is least significant.
REQ-013 SHALL have port seg  out  7  active-low cathodes ordered {a,b,c,d,e,f,g}.
REQ-014 SHALL have port dp  out  1  active-low decimal-point cathode.

Function
REQ-015 Prescaler SHALL count 0..PRESCALE-1 and emit one tick at the terminal count, then wrap to 0.
REQ-016 Scan index SHALL advance on each tick, wrapping NUM_DIGITS-1 to 0.
REQ-017 an, seg and dp SHALL be registered and SHALL reflect the new index one cycle after the tick.
REQ-018 At most one an bit SHALL be low; if digit_en[index]=0, all an bits SHALL be high, seg=7'h7F and dp=1.
REQ-019 Hex glyphs SHALL be: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-020 load with busy=0 and dec_mode=0 SHALL update the display register and dp register on the next cycle and SHALL clear ovf.
REQ-021 load with busy=0 and dec_mode=1 SHALL start a shift-add-3 conversion.
REQ-022 During that conversion, busy SHALL be high for exactly 4*NUM_DIGITS cycles starting the cycle after load, with one bit processed per cycle.
REQ-023 The display register and ovf SHALL update atomically on the cycle busy falls.
REQ-024 The previous value SHALL remain displayed throughout a conversion.
REQ-025 ovf SHALL be set if any 1 bit is shifted out of the top BCD digit during conversion.
REQ-026 While ovf=1, every enabled digit SHALL show a dash (seg=1111110).
REQ-027 load while busy=1 SHALL be ignored, with no effect on the conversion, display register, dp register or ovf.
REQ-028 load and tick in the same cycle SHALL be handled independently, with neither delayed.

Reset
REQ-029 rst SHALL set the prescaler, scan index, display register, dp register, busy and ovf to 0.
REQ-030 rst SHALL set an to all ones, seg to 7'h7F and dp to 1.
REQ-031 rst during a conversion SHALL abort it, with no display update afterwards.

Configuration
REQ-032 With macro SSD_LZ_BLANK_EN defined, leading zero digits above the most significant nonzero digit SHALL be blanked (an high).
REQ-033 Under SSD_LZ_BLANK_EN, digit 0 SHALL never be blanked, and blanking SHALL NOT apply while ovf=1.
REQ-034 Without SSD_LZ_BLANK_EN, every enabled digit SHALL display its nibble, and the blanking logic SHALL be absent.

Structure
REQ-035 Package ssd_pkg SHALL hold the 16 glyph constants, SEG_BLANK=7'h7F and SEG_DASH=7'b1111110.
REQ-036 The conversion SHALL be sub-module bin2bcd_seq (start/busy/done, parameter width).

Verification (NUM_DIGITS=4, PRESCALE=4)
REQ-037 Bench SHALL cover: assert rst for 2 cycles -> an=1111, seg=1111111, dp=1, busy=0, ovf=0.
REQ-038 Bench SHALL cover: hex load 16'h1A3F, digit_en=1111 -> digits 0..3 show 0111000, 0000110, 0001000, 1001111, each an low for 4 cycles.
REQ-039 Bench SHALL cover: decimal load 16'd1234 -> busy high 16 cycles, old value shown meanwhile, then digits 0..3 show 4, 3, 2, 1, ovf=0.
REQ-040 Bench SHALL cover: decimal load 16'd12345 -> ovf=1, all digits 1111110; a later hex load 16'h0007 -> ovf=0.
REQ-041 Bench SHALL cover: load 16'h9999 at busy cycle 5 -> ignored; rst at busy cycle 8 -> busy=0, display 0000, an=1111.
REQ-042 Bench SHALL cover, with SSD_LZ_BLANK_EN: hex 16'h0042 -> an[3], an[2] stay high; hex 16'h0000 -> only digit 0 lit, showing 0.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan multiplexer.
// Segment patterns are active-low and ordered {a,b,c,d,e,f,g}.
// Contents: 16 hex glyph constants, SEG_BLANK, SEG_DASH, and the
// hex_glyph() lookup helper.
package ssd_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0111000;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1111110;

  // Nibble to active-low glyph.
  function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] nib);
    logic [SEG_W-1:0] g;
    case (nib)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = SEG_A;
      4'hB:    g = SEG_B;
      4'hC:    g = SEG_C;
      4'hD:    g = SEG_D;
      4'hE:    g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ssd_scan_mux_bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per
// cycle, WIDTH cycles of busy per conversion. WIDTH must be a multiple of 4.
// Ports:
//   clk, rst   clock, synchronous active-high reset (aborts a conversion)
//   start      begin a conversion of bin (ignored while busy)
//   bin        binary operand
//   busy       conversion in progress (registered)
//   done_c     high during the last busy cycle; bcd_c/ovf_c are final then
//   bcd_c      BCD result as it will stand after this cycle's step
//   ovf_c      a 1 has been shifted out of the top BCD digit
module bin2bcd_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done_c,
  output logic [WIDTH-1:0] bcd_c,
  output logic             ovf_c
);

  localparam int unsigned DIGITS = WIDTH / 4;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] bcd_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] adj;

  // Add-3 correction on every digit >= 5, then shift one operand bit in.
  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    bcd_c  = {adj[WIDTH-2:0], sh_q[WIDTH-1]};
    ovf_c  = ovf_q | adj[WIDTH-1];
    done_c = busy && (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (busy) begin
      sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
      bcd_q <= bcd_c;
      ovf_q <= ovf_c;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy <= 1'b0;
    end else if (start) begin
      sh_q  <= bin;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= CNT_W'(WIDTH);
      busy  <= 1'b1;
    end
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// Multiplexed seven-segment display driver with hex or binary-to-decimal
// display modes and per-digit enables.
// Optional feature: define SSD_LZ_BLANK_EN to blank leading zero digits.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       strobe capturing value, dec_mode and dp_in (ignored while busy)
//   value      hex nibbles or unsigned binary (dec_mode=1)
//   dec_mode   1 converts value to decimal before display
//   dp_in      per-digit decimal point, 1 = lit
//   digit_en   live per-digit enable, 0 blanks that digit
//   busy       decimal conversion in progress
//   ovf        last decimal load did not fit in NUM_DIGITS digits
//   an         active-low anodes, bit 0 = least significant digit
//   seg        active-low cathodes {a,b,c,d,e,f,g}
//   dp         active-low decimal point cathode
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned PRESCALE   = 131072
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    dec_mode,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    busy,
  output logic                    ovf,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]      pre_q;
  logic                  tick;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_nxt;
  logic [VAL_W-1:0]      disp_q;
  logic [NUM_DIGITS-1:0] dpr_q;
  logic [NUM_DIGITS-1:0] dp_hold_q;
  logic                  accept;
  logic                  start;
  logic                  conv_done;
  logic [VAL_W-1:0]      conv_bcd;
  logic                  conv_ovf;
  logic [VAL_W-1:0]      upper;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [SEG_W-1:0]      seg_nxt;
  logic                  dp_nxt;

  assign tick   = (pre_q == CNT_W'(PRESCALE - 1));
  assign accept = load && !busy;
  assign start  = accept && dec_mode;

  // Scan index as it will be after this edge; outputs follow it directly.
  always_comb begin
    idx_nxt = idx_q;
    if (tick) idx_nxt = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
  end

  bin2bcd_seq #(
    .WIDTH (VAL_W)
  ) u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin    (value),
    .busy   (busy),
    .done_c (conv_done),
    .bcd_c  (conv_bcd),
    .ovf_c  (conv_ovf)
  );

  // Glyph selection for the digit being scanned next.
  always_comb begin
    upper   = disp_q >> {idx_nxt, 2'b00};
    lit     = digit_en[idx_nxt];
`ifdef SSD_LZ_BLANK_EN
    // Selected nibble and everything above it zero: leading zero.
    if (!ovf && (idx_nxt != '0) && (upper == '0)) lit = 1'b0;
`endif
    an_nxt  = '1;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (lit) begin
      an_nxt  = ~(NUM_DIGITS'(1) << idx_nxt);
      seg_nxt = ovf ? SEG_DASH : hex_glyph(upper[3:0]);
      dp_nxt  = ~dpr_q[idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      dpr_q     <= '0;
      dp_hold_q <= '0;
      ovf       <= 1'b0;
      an        <= '1;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      pre_q <= tick ? '0 : pre_q + CNT_W'(1);
      idx_q <= idx_nxt;
      an    <= an_nxt;
      seg   <= seg_nxt;
      dp    <= dp_nxt;
      // Decimal result, its ovf and its decimal points commit together.
      if (conv_done) begin
        disp_q <= conv_bcd;
        ovf    <= conv_ovf;
        dpr_q  <= dp_hold_q;
      end
      if (accept) begin
        if (dec_mode) begin
          dp_hold_q <= dp_in;
        end else begin
          disp_q <= value;
          dpr_q  <= dp_in;
          ovf    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Self-checking bench for ssd_scan_mux (NUM_DIGITS=4, PRESCALE=4): directed
// scenarios followed by random traffic, all compared every cycle against a
// behavioural model of the display.
module tb_ssd_scan_mux;

  localparam int N = 4;
  localparam int P = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [15:0]   value;
  logic          dec_mode;
  logic [N-1:0]  dp_in;
  logic [N-1:0]  digit_en;
  logic          busy;
  logic          ovf;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model state
  int           m_cnt, m_idx, m_pend, m_val;
  logic [15:0]  m_disp;
  logic [N-1:0] m_dpr, m_dph;
  logic         m_ovf;
  logic [N-1:0] e_an;
  logic [6:0]   e_seg;
  logic         e_dp;

  ssd_scan_mux #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .dec_mode (dec_mode),
    .dp_in    (dp_in),
    .digit_en (digit_en),
    .busy     (busy),
    .ovf      (ovf),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
  endtask

  function automatic logic [6:0] glyph(input int nib);
    case (nib)
      0: return 7'b0000001;  1: return 7'b1001111;
      2: return 7'b0010010;  3: return 7'b0000110;
      4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;
      8: return 7'b0000000;  9: return 7'b0000100;
      10: return 7'b0001000; 11: return 7'b1100000;
      12: return 7'b0110001; 13: return 7'b1000010;
      14: return 7'b0110000; default: return 7'b0111000;
    endcase
  endfunction

  // Decimal digits of v packed as nibbles, by repeated division.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < N; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_edge();
    bit tick, lit, was_busy;
    int nib, upper;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_pend = 0; m_val = 0;
      m_disp = '0; m_dpr = '0; m_dph = '0; m_ovf = 1'b0;
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
      return;
    end
    tick  = (m_cnt == P - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    if (tick) m_idx = (m_idx + 1) % N;
    upper = int'(m_disp) >> (4 * m_idx);
    nib   = upper % 16;
    lit   = digit_en[m_idx];
`ifdef SSD_LZ_BLANK_EN
    if (!m_ovf && m_idx != 0 && upper == 0) lit = 1'b0;
`endif
    if (lit) begin
      e_an  = ~(N'(1) << m_idx);
      e_seg = m_ovf ? 7'b1111110 : glyph(nib);
      e_dp  = ~m_dpr[m_idx];
    end else begin
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
    end
    was_busy = (m_pend > 0);
    if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        m_disp = to_bcd(m_val % 10000);
        m_ovf  = (m_val >= 10000);
        m_dpr  = m_dph;
      end
    end
    if (load && !was_busy) begin
      if (dec_mode) begin
        m_pend = 4 * N; m_val = int'(value); m_dph = dp_in;
      end else begin
        m_disp = value; m_dpr = dp_in; m_ovf = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("an",   32'(an),   32'(e_an));
    check("seg",  32'(seg),  32'(e_seg));
    check("dp",   32'(dp),   32'(e_dp));
    check("busy", 32'(busy), 32'(m_pend > 0));
    check("ovf",  32'(ovf),  32'(m_ovf));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [15:0] v, input logic dec, input logic [N-1:0] dpv);
    load = 1'b1; value = v; dec_mode = dec; dp_in = dpv;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dec_mode = 1'b0;
    dp_in = '0; digit_en = '1;
    run(2);
    check("reset_an",  32'(an),  32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    rst = 1'b0;

    do_load(16'h1A3F, 1'b0, 4'b0000);
    run(20);
    do_load(16'd1234, 1'b1, 4'b0100);
    run(24);
    do_load(16'd12345, 1'b1, 4'b0000);
    run(24);
    check("ovf_set", 32'(ovf), 32'h1);
    do_load(16'h0007, 1'b0, 4'b0001);
    run(10);
    check("ovf_clr", 32'(ovf), 32'h0);

    // Load during conversion ignored, reset aborts the conversion.
    do_load(16'd4321, 1'b1, 4'b0000);
    run(3);
    do_load(16'h9999, 1'b0, 4'b1111);
    run(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    run(24);

    do_load(16'h0042, 1'b0, 4'b0000);
    run(16);
    do_load(16'h0000, 1'b0, 4'b0000);
    run(16);
    digit_en = 4'b1010;
    do_load(16'h8C5E, 1'b0, 4'b1001);
    run(16);
    digit_en = '1;

    for (int i = 0; i < 1200; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      load     = ($urandom_range(0, 9) == 0);
      dec_mode = 1'($urandom_range(0, 1));
      value    = (dec_mode && $urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 9999))
                                                         : 16'($urandom);
      dp_in    = N'($urandom);
      if ($urandom_range(0, 31) == 0) digit_en = N'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
